// File: rtl/fu_alu_exec.sv
// fu_alu_exec: single-lane ALU execution unit with a multi-cycle multiply and a 2-entry CDB output buffer
// Ports: clk, rst (sync active-low) | RS issue: RS_FU_RS_ID, RS_FU_ROBEN, RS_FU_opcode, RS_FU_ALUOP,
// RS_FU_Val1, RS_FU_Val2, RS_FU_Immediate | ROB_FLUSH_Flag squash | CDB: CDB_GRANT in;
// CDB_VALID, CDB_ROBEN, CDB_ROBEN_VAL out | FU_Is_Free back-pressure to the RS
module fu_alu_exec #(
  parameter int MUL_LAT = 3,
  parameter int OUTQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS_FU_RS_ID,
  input  logic [4:0]  RS_FU_ROBEN,
  input  logic [11:0] RS_FU_opcode,
  input  logic [3:0]  RS_FU_ALUOP,
  input  logic [31:0] RS_FU_Val1,
  input  logic [31:0] RS_FU_Val2,
  input  logic [31:0] RS_FU_Immediate,
  input  logic        ROB_FLUSH_Flag,
  input  logic        CDB_GRANT,
  output logic        FU_Is_Free,
  output logic        CDB_VALID,
  output logic [4:0]  CDB_ROBEN,
  output logic [31:0] CDB_ROBEN_VAL
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  count;
  logic        wptr, rptr;
  logic [4:0]  q_rob [2];
  logic [31:0] q_val [2];
  logic [31:0] mul_a, mul_b;
  logic [4:0]  mul_rob;
  logic [31:0] op_b, alu_res, push_val;
  logic [4:0]  push_rob;
  logic        accept, is_mul, mul_done, push, pop;
  logic        unused_bits;
  assign unused_bits = ^RS_FU_opcode[10:0];
  assign FU_Is_Free = state == IDLE && count < 2'(OUTQ_DEPTH) && rst;
  assign accept = RS_FU_RS_ID != '0 && RS_FU_ROBEN != '0 && FU_Is_Free && !ROB_FLUSH_Flag;
  assign op_b = RS_FU_opcode[11] ? RS_FU_Immediate : RS_FU_Val2;
  assign is_mul = RS_FU_ALUOP == 4'd11;
  // completion stalls with cnt held at 1 while the buffer is full
  assign mul_done = state == MUL && cnt == 4'd1 && count != 2'd2;
  // accept implies IDLE, so a single-cycle push and a mul completion never coincide
  assign push = (accept && !is_mul) || mul_done;
  assign push_rob = mul_done ? mul_rob : RS_FU_ROBEN;
  // low 32 bits of the product are identical for signed and unsigned operands
  assign push_val = mul_done ? mul_a * mul_b : alu_res;
  assign CDB_VALID = count != 2'd0;
  assign pop = CDB_GRANT && CDB_VALID;
  assign CDB_ROBEN = CDB_VALID ? q_rob[rptr] : '0;
  assign CDB_ROBEN_VAL = CDB_VALID ? q_val[rptr] : '0;
  always_comb begin
    alu_res = '0;
    case (RS_FU_ALUOP)
      4'd0:  alu_res = RS_FU_Val1 + op_b;
      4'd1:  alu_res = RS_FU_Val1 - op_b;
      4'd2:  alu_res = RS_FU_Val1 & op_b;
      4'd3:  alu_res = RS_FU_Val1 | op_b;
      4'd4:  alu_res = RS_FU_Val1 ^ op_b;
      4'd5:  alu_res = ~(RS_FU_Val1 | op_b);
      4'd6:  alu_res = RS_FU_Val1 << op_b[4:0];
      4'd7:  alu_res = RS_FU_Val1 >> op_b[4:0];
      4'd8:  alu_res = $signed(RS_FU_Val1) >>> op_b[4:0];
      4'd9:  alu_res = {31'd0, $signed(RS_FU_Val1) < $signed(op_b)};
      4'd10: alu_res = {31'd0, RS_FU_Val1 < op_b};
      default: alu_res = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      count <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      mul_rob <= '0;
    end else if (ROB_FLUSH_Flag) begin
      state <= IDLE;
      cnt <= '0;
      count <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (push) begin
        q_rob[wptr] <= push_rob;
        q_val[wptr] <= push_val;
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (accept && is_mul) begin
        state <= MUL;
        cnt <= 4'(MUL_LAT - 1);
        mul_a <= RS_FU_Val1;
        mul_b <= op_b;
        mul_rob <= RS_FU_ROBEN;
      end else if (state == MUL) begin
        if (mul_done) begin
          state <= IDLE;
          cnt <= '0;
        end else if (cnt != 4'd1) cnt <= cnt - 4'd1;
      end
    end
  end
endmodule
